spi_slave_ctrl: RTL and testbench
=================================

Name: spi_slave_ctrl

Overview:
- Control FSM that sequences the SPI slave datapath: shift counter, input and output shift registers, address register, address mux, 256 x 8 register file and command comparator.
- Frame format (SPI mode 0, MSB first): command byte, then address byte, then data bytes.
- Command 0x03 (datapath CMP_OUT=1) is a burst READ; any other command is a burst WRITE.
- Generates all datapath enables from CNT_TICK, CNT_SIX_TICK and CMP_OUT; exports frame status.

Parameters:
- AUTO_INC, 1, 1 = address increments after every data byte; 0 = every data byte uses the same address.
- CNT_W, 8, width of the XFER_CNT status counter.

Ports:
- SCLK  input  1  SPI serial clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous active-low reset; top level drives it from inverted chip select, so deselect aborts the frame.
- CNT_TICK  input  1  datapath bit counter == 7.
- CNT_SIX_TICK  input  1  datapath bit counter == 6.
- CMP_OUT  input  1  registered "command == 0x03".
- CNT_EN  output  1  bit counter enable.
- IN_SHIFT_EN  output  1  MOSI shift enable.
- OUT_SHIFT_EN  output  1  MISO shift enable (datapath acts on falling edge).
- WRITE_EN  output  1  register-file write (datapath acts on falling edge).
- DATA_LOAD_EN  output  1  load output shifter from the register file (falling edge).
- MUX_SEL  output  1  1 = Address_reg, 0 = raw input shift register.
- CMP_EN  output  1  capture command compare.
- ADD_WR_EN  output  1  load Address_reg from the input shift register.
- ADD_INCREMENT  output  1  Address_reg + 1.
- STATE  output  2  0 CMD, 1 ADDR, 2 WR, 3 RD.
- XFER_CNT  output  CNT_W  completed data bytes in the current frame; saturates at all-ones.

Behaviour:
- Registers:
  - state.
  - byte_done: set for exactly one cycle after each rising edge that sampled CNT_TICK=1.
  - first_data: set for one cycle after the ADDR byte completes.
  - XFER_CNT.
- RST_N low (asynchronous): state=CMD, byte_done=0, first_data=0, XFER_CNT=0. All outputs are 0 while RST_N is low, because every enable is gated by RST_N.
- Transitions (only on a rising edge with CNT_TICK=1):
  - CMD -> ADDR.
  - ADDR -> RD if CMP_OUT=1, else WR.
  - WR and RD remain until reset.
  - Illegal or unused encodings are impossible with 2 bits; the default branch returns to CMD.
- Decode, all combinational from registered state and flags:
  - CNT_EN = IN_SHIFT_EN = RST_N in every state.
  - CMP_EN = (state==ADDR) & byte_done. This is the first cycle of ADDR, when the input shift register holds the full command.
  - ADD_WR_EN = first_data. The address is latched on the first rising edge of the first data byte.
  - MUX_SEL = 0 in CMD and ADDR, and in RD while first_data=1; otherwise 1.
  - WRITE_EN = (state==WR) & byte_done & ~first_data. The write occurs on the falling edge after the 8th data bit, using Address_reg.
  - ADD_INCREMENT, two sources:
    - In WR: (state==WR) & byte_done & ~first_data & AUTO_INC, i.e. the increment follows the write.
    - In RD: (state==RD) & CNT_SIX_TICK & AUTO_INC. The early increment lets the next load see address+1.
  - DATA_LOAD_EN = (state==RD) & byte_done.
  - OUT_SHIFT_EN = (state==RD) & ~byte_done.
- First read byte: loaded through MUX_SEL=0 (raw address) in the cycle after the address byte, so its MSB is on MISO before the next rising edge. No dead byte.
- XFER_CNT increments on each rising edge with byte_done=1 in WR (excluding first_data) or in RD. No increment at saturation.
- Address wrap 0xFF -> 0x00 is inherent to the 8-bit datapath; the controller takes no special action.
- Reset mid-byte or mid-burst: partial byte discarded, no WRITE_EN pulse is produced, and the next frame starts in CMD.
- CNT_TICK and CNT_SIX_TICK are never simultaneous. If they are, CNT_TICK handling takes precedence and the increment is still issued.

Test Plan:
- Write burst: frame 0x02, 0x10, 0xAA, 0x55 -> WRITE_EN pulses exactly twice; reg[0x10]=0xAA, reg[0x11]=0x55; XFER_CNT=2; STATE=2.
- Read burst: preload reg[0x20]=0x3C, reg[0x21]=0xC3; frame 0x03, 0x20, then 16 dummy clocks -> MISO shows 0x3C then 0xC3 MSB first; ADD_INCREMENT high at counter==6 of each data byte.
- Wrap: write 0x02, 0xFF, 0x11, 0x22 -> reg[0xFF]=0x11, reg[0x00]=0x22. Read 0x03, 0xFF over 2 bytes -> 0x11, 0x22.
- AUTO_INC=0: write 0x02, 0x40, 0x01, 0x02 -> reg[0x40]=0x02, reg[0x41] unchanged, ADD_INCREMENT never asserted.
- Abort: RST_N low after 4 bits of the second data byte of a write -> outputs 0 immediately, STATE=0, XFER_CNT=0, only the first byte written. The next frame 0x03, 0x10 reads correctly.
- Non-read command 0x7E -> treated as WRITE; CMP_EN pulses once in the first ADDR cycle; CMP_OUT=0; STATE=2.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// Control FSM for the SPI slave datapath: walks CMD -> ADDR -> WR/RD once per frame
// and decodes every datapath enable from the registered state and per-byte flags.
module spi_slave_ctrl #(
    parameter bit AUTO_INC = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             SCLK,
    input  logic             RST_N,
    input  logic             CNT_TICK,
    input  logic             CNT_SIX_TICK,
    input  logic             CMP_OUT,
    output logic             CNT_EN,
    output logic             IN_SHIFT_EN,
    output logic             OUT_SHIFT_EN,
    output logic             WRITE_EN,
    output logic             DATA_LOAD_EN,
    output logic             MUX_SEL,
    output logic             CMP_EN,
    output logic             ADD_WR_EN,
    output logic             ADD_INCREMENT,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] XFER_CNT
);

    typedef enum logic [1:0] {
        S_CMD  = 2'd0,
        S_ADDR = 2'd1,
        S_WR   = 2'd2,
        S_RD   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             byte_done_q, byte_done_d;
    logic             first_data_q, first_data_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;

    logic in_wr, in_rd, wr_byte, xfer_evt, inc_en;

    assign in_wr    = (state_q == S_WR);
    assign in_rd    = (state_q == S_RD);
    // The byte_done that closes the address byte is not a data byte in a write.
    assign wr_byte  = in_wr & byte_done_q & ~first_data_q;
    assign xfer_evt = wr_byte | (in_rd & byte_done_q);
    assign inc_en   = AUTO_INC;

    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_CMD;
            byte_done_q  <= 1'b0;
            first_data_q <= 1'b0;
            xfer_q       <= '0;
        end else begin
            state_q      <= state_d;
            byte_done_q  <= byte_done_d;
            first_data_q <= first_data_d;
            xfer_q       <= xfer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_done_d  = CNT_TICK;
        first_data_d = (state_q == S_ADDR) & CNT_TICK;
        xfer_d       = xfer_q;
        if (CNT_TICK) begin
            case (state_q)
                S_CMD:   state_d = S_ADDR;
                S_ADDR:  state_d = CMP_OUT ? S_RD : S_WR;
                S_WR:    state_d = S_WR;
                S_RD:    state_d = S_RD;
                default: state_d = S_CMD;
            endcase
        end
        if (xfer_evt && (xfer_q != {CNT_W{1'b1}}))
            xfer_d = xfer_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Every output is forced low while RST_N is low, so chip deselect silences the datapath.
    always_comb begin
        CNT_EN        = RST_N;
        IN_SHIFT_EN   = RST_N;
        CMP_EN        = RST_N & (state_q == S_ADDR) & byte_done_q;
        ADD_WR_EN     = RST_N & first_data_q;
        MUX_SEL       = RST_N & (in_wr | (in_rd & ~first_data_q));
        WRITE_EN      = RST_N & wr_byte;
        // RD increments at bit 6 so the load on the next byte boundary already sees addr+1.
        ADD_INCREMENT = RST_N & inc_en & (wr_byte | (in_rd & CNT_SIX_TICK));
        DATA_LOAD_EN  = RST_N & in_rd & byte_done_q;
        OUT_SHIFT_EN  = RST_N & in_rd & ~byte_done_q;
        STATE         = RST_N ? state_q : 2'd0;
        XFER_CNT      = RST_N ? xfer_q : '0;
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomized frames against a cycle-index model of the SPI controller; two instances
// cover AUTO_INC=1 with a narrow saturating counter and AUTO_INC=0 with the default width.
module tb_spi_slave_ctrl;

    logic SCLK = 1'b0;
    logic RST_N, CNT_TICK, CNT_SIX_TICK, CMP_OUT;

    logic       cnt_en, in_en, out_en, wr_en, ld_en, mux, cmp_en, awr, ainc;
    logic [1:0] st;
    logic [3:0] xfer;

    logic       cnt_en_n, in_en_n, out_en_n, wr_en_n, ld_en_n, mux_n, cmp_en_n, awr_n, ainc_n;
    logic [1:0] st_n;
    logic [7:0] xfer_n;

    int n_cmp = 0;
    int n_err = 0;
    bit fr_rd;
    logic [7:0] fr_cmd;

    always #5 SCLK = ~SCLK;

    spi_slave_ctrl #(.AUTO_INC(1'b1), .CNT_W(4)) u_dut (
        .SCLK(SCLK), .RST_N(RST_N), .CNT_TICK(CNT_TICK), .CNT_SIX_TICK(CNT_SIX_TICK),
        .CMP_OUT(CMP_OUT), .CNT_EN(cnt_en), .IN_SHIFT_EN(in_en), .OUT_SHIFT_EN(out_en),
        .WRITE_EN(wr_en), .DATA_LOAD_EN(ld_en), .MUX_SEL(mux), .CMP_EN(cmp_en),
        .ADD_WR_EN(awr), .ADD_INCREMENT(ainc), .STATE(st), .XFER_CNT(xfer)
    );

    spi_slave_ctrl #(.AUTO_INC(1'b0), .CNT_W(8)) u_dut_ni (
        .SCLK(SCLK), .RST_N(RST_N), .CNT_TICK(CNT_TICK), .CNT_SIX_TICK(CNT_SIX_TICK),
        .CMP_OUT(CMP_OUT), .CNT_EN(cnt_en_n), .IN_SHIFT_EN(in_en_n), .OUT_SHIFT_EN(out_en_n),
        .WRITE_EN(wr_en_n), .DATA_LOAD_EN(ld_en_n), .MUX_SEL(mux_n), .CMP_EN(cmp_en_n),
        .ADD_WR_EN(awr_n), .ADD_INCREMENT(ainc_n), .STATE(st_n), .XFER_CNT(xfer_n)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
        end
    endtask

    // Number of byte boundaries (multiples of 8) in [lo, hi].
    function automatic int bounds(input int lo, input int hi);
        return (hi < lo) ? 0 : (hi - lo) / 8 + 1;
    endfunction

    task automatic chk_zero();
        chk("rst.cnt_en", {cnt_en, cnt_en_n}, 0);
        chk("rst.in_en", {in_en, in_en_n}, 0);
        chk("rst.out_en", {out_en, out_en_n}, 0);
        chk("rst.wr_en", {wr_en, wr_en_n}, 0);
        chk("rst.ld_en", {ld_en, ld_en_n}, 0);
        chk("rst.mux", {mux, mux_n}, 0);
        chk("rst.cmp_en", {cmp_en, cmp_en_n}, 0);
        chk("rst.awr", {awr, awr_n}, 0);
        chk("rst.ainc", {ainc, ainc_n}, 0);
        chk("rst.state", {st, st_n}, 0);
        chk("rst.xfer", {xfer, xfer_n}, 0);
    endtask

    // Expected outputs in cycle k of the frame (k = rising edges since reset release).
    task automatic chk_cycle(input int k);
        int  st_e, cnt;
        bit  bd, data, wbyte;
        st_e  = (k < 8) ? 0 : (k < 16) ? 1 : (fr_rd ? 3 : 2);
        bd    = (k >= 8) && (k % 8 == 0);
        data  = (k >= 16);
        wbyte = data && !fr_rd && (k >= 24) && bd;
        cnt   = fr_rd ? bounds(16, k - 1) : bounds(24, k - 1);
        chk("cnt_en", {cnt_en, cnt_en_n, in_en, in_en_n}, 4'hF);
        chk("state", st, st_e);
        chk("state_ni", st_n, st_e);
        chk("cmp_en", {cmp_en, cmp_en_n}, {2{k == 8}});
        chk("add_wr_en", {awr, awr_n}, {2{k == 16}});
        chk("mux_sel", {mux, mux_n}, {2{data && !(fr_rd && k == 16)}});
        chk("write_en", {wr_en, wr_en_n}, {2{wbyte}});
        chk("data_load", {ld_en, ld_en_n}, {2{data && fr_rd && bd}});
        chk("out_shift", {out_en, out_en_n}, {2{data && fr_rd && !bd}});
        chk("add_inc", ainc, wbyte || (data && fr_rd && (k % 8 == 6)));
        chk("add_inc_ni", ainc_n, 0);
        chk("xfer_cnt", xfer, (cnt > 15) ? 15 : cnt);
        chk("xfer_cnt_ni", xfer_n, (cnt > 255) ? 255 : cnt);
    endtask

    task automatic drive(input int k);
        CNT_TICK     = (k % 8 == 7);
        CNT_SIX_TICK = (k % 8 == 6);
        // Comparator result is registered at the end of the CMP_EN cycle (k==8).
        CMP_OUT      = (k >= 9) ? (fr_cmd == 8'h03) : 1'b0;
    endtask

    task automatic hold_reset(input int n);
        RST_N = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge SCLK);
            CNT_TICK     = 1'($urandom);
            CNT_SIX_TICK = 1'($urandom);
            CMP_OUT      = 1'($urandom);
            #1 chk_zero();
        end
    endtask

    // Runs ncyc cycles of a frame, then drops RST_N asynchronously mid-cycle.
    task automatic run_frame(input logic [7:0] cmd, input int ncyc);
        fr_cmd = cmd;
        fr_rd  = (cmd == 8'h03);
        @(negedge SCLK);
        RST_N = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge SCLK);
            drive(k);
            #1 chk_cycle(k);
        end
        #2 RST_N = 1'b0;
        #1 chk_zero();
    endtask

    initial begin
        logic [7:0] cmd;
        RST_N = 1'b0;
        CNT_TICK = 1'b0;
        CNT_SIX_TICK = 1'b0;
        CMP_OUT = 1'b0;
        hold_reset(3);
        run_frame(8'h02, 33);      // write 2 data bytes
        hold_reset(2);
        run_frame(8'h03, 32);      // read 2 data bytes
        hold_reset(2);
        run_frame(8'h02, 28);      // abort 4 bits into second data byte
        hold_reset(1);
        run_frame(8'h03, 20);
        hold_reset(1);
        run_frame(8'h7E, 26);      // non-read command
        hold_reset(1);
        run_frame(8'h02, 180);     // saturates the narrow counter
        hold_reset(1);
        run_frame(8'h03, 180);
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 3))
                0:       cmd = 8'h03;
                1:       cmd = 8'h02;
                default: cmd = 8'($urandom);
            endcase
            hold_reset($urandom_range(1, 3));
            run_frame(cmd, $urandom_range(4, 170));
        end
        hold_reset(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
